// File: rtl/tcp_pkg.sv
// tcp_pkg: shared TCP transmit types, header constants and header assembly helper.
package tcp_pkg;

    localparam int         TCP_HDR_BYTES   = 20;
    localparam logic [7:0] TCP_FLAG_SYN    = 8'h02;
    localparam logic [7:0] TCP_FLAG_ACK    = 8'h10;
    localparam logic [7:0] TCP_FLAG_FIN    = 8'h01;
    localparam logic [7:0] TCP_DATA_OFFSET = 8'h50;

    typedef enum logic [1:0] {
        TX_CTRL_NOP,
        TX_CTRL_SEND_SYN,
        TX_CTRL_SEND_ACK,
        TX_CTRL_SEND_FIN
    } tx_ctrl_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // Element 0 is the first byte on the wire, so the counter indexes it directly.
    typedef logic [0:TCP_HDR_BYTES-1][7:0] hdr_t;

    // Checksum and urgent pointer go out as zero; checksum is filled downstream.
    function automatic hdr_t build_hdr(
        input logic [15:0] src,
        input logic [15:0] dst,
        input logic [31:0] seq,
        input logic [31:0] ack,
        input logic [7:0]  flags,
        input logic [15:0] window
    );
        return {src, dst, seq, ack, TCP_DATA_OFFSET, flags, window, 16'h0000, 16'h0000};
    endfunction

endpackage

// File: rtl/tcp_tx_ctrl_if.sv
// tcp_tx_ctrl_if: command handshake plus AXI-Stream header byte output.
//   i_tx_ctrl/i_tx_ctrl_valid/o_tx_ctrl_ack : command from the state manager
//   o_m_axis_tdata/tvalid/tlast, i_m_axis_tready : header byte stream
//   master: command source and stream sink; slave: tcp_tx_ctrl
interface tcp_tx_ctrl_if;
    import tcp_pkg::*;

    tx_ctrl_t   i_tx_ctrl;
    logic       i_tx_ctrl_valid;
    logic       o_tx_ctrl_ack;
    logic [7:0] o_m_axis_tdata;
    logic       o_m_axis_tvalid;
    logic       i_m_axis_tready;
    logic       o_m_axis_tlast;

    modport master (
        output i_tx_ctrl, i_tx_ctrl_valid, i_m_axis_tready,
        input  o_tx_ctrl_ack, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast
    );

    modport slave (
        input  i_tx_ctrl, i_tx_ctrl_valid, i_m_axis_tready,
        output o_tx_ctrl_ack, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast
    );

endinterface

// File: rtl/tcp_tx_ctrl.sv
// tcp_tx_ctrl: accepts SYN/ACK/FIN commands and streams a 20-byte TCP header.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_enable              : block enable, sampled only when accepting commands
//   i_src_port..i_window  : header fields captured on the accept edge
//   bus (slave)           : command handshake and header byte stream
//   o_busy                : header in flight
//   o_snd_nxt             : current SND.NXT
module tcp_tx_ctrl
    import tcp_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_enable,
    input  logic [15:0]   i_src_port,
    input  logic [15:0]   i_dst_port,
    input  logic [31:0]   i_iss,
    input  logic [31:0]   i_rcv_nxt,
    input  logic [15:0]   i_window,
    tcp_tx_ctrl_if.slave  bus,
    output logic          o_busy,
    output logic [31:0]   o_snd_nxt
);

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    hdr_t        hdr;
    logic [31:0] snd_nxt;
    tx_ctrl_t    cmd;
    logic        accept, start, beat, last;
    logic [31:0] seq, ack_num;
    logic [7:0]  flags;

    // Ack is gated by reset so it reads low while reset is held.
    always_comb begin
        cmd     = bus.i_tx_ctrl;
        accept  = i_rst_n && state == ST_IDLE && bus.i_tx_ctrl_valid && i_enable;
        start   = accept && cmd != TX_CTRL_NOP;
        beat    = state == ST_SEND && bus.i_m_axis_tready;
        last    = cnt == 5'(TCP_HDR_BYTES - 1);
        seq     = cmd == TX_CTRL_SEND_SYN ? i_iss : snd_nxt;
        ack_num = cmd == TX_CTRL_SEND_SYN ? 32'h0 : i_rcv_nxt;
        flags   = cmd == TX_CTRL_SEND_SYN ? TCP_FLAG_SYN :
                  cmd == TX_CTRL_SEND_FIN ? (TCP_FLAG_ACK | TCP_FLAG_FIN) : TCP_FLAG_ACK;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == ST_IDLE ? (start ? ST_SEND : ST_IDLE) :
                    (beat && last)   ? ST_IDLE : ST_SEND;
    end

    always_comb begin
        bus.o_tx_ctrl_ack   = accept;
        bus.o_m_axis_tvalid = state == ST_SEND;
        bus.o_m_axis_tlast  = state == ST_SEND && last;
        bus.o_m_axis_tdata  = state == ST_SEND ? hdr[cnt] : 8'h00;
        o_busy              = state == ST_SEND;
        o_snd_nxt           = snd_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            hdr     <= '0;
            snd_nxt <= '0;
        end else begin
            if (start)
                cnt <= '0;
            else if (beat)
                cnt <= last ? 5'd0 : cnt + 5'd1;
            if (start)
                hdr <= build_hdr(i_src_port, i_dst_port, seq, ack_num, flags, i_window);
            if (accept && cmd == TX_CTRL_SEND_SYN)
                snd_nxt <= i_iss + 32'd1;
            else if (accept && cmd == TX_CTRL_SEND_FIN)
                snd_nxt <= snd_nxt + 32'd1;
        end
    end

endmodule

// File: tb/tb_tcp_tx_ctrl.sv
// tb_tcp_tx_ctrl: table, directed and random checks of tcp_tx_ctrl against a byte-queue model.
module tb_tcp_tx_ctrl;
    import tcp_pkg::*;

    typedef struct {
        tx_ctrl_t    cmd;
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] iss;
        logic [31:0] rcv;
        logic [15:0] win;
        logic [31:0] exp_snd;
        logic [7:0]  exp_flags;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [15:0] src, dst, win;
    logic [31:0] iss, rcv;
    logic        busy;
    logic [31:0] snd_nxt;

    tcp_tx_ctrl_if bus();

    tcp_tx_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_src_port (src),
        .i_dst_port (dst),
        .i_iss      (iss),
        .i_rcv_nxt  (rcv),
        .i_window   (win),
        .bus        (bus),
        .o_busy     (busy),
        .o_snd_nxt  (snd_nxt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_snd;
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_flags;
    int          hs, nl;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            exp_q.push_back(v[8*i +: 8]);
    endtask

    // Expected wire bytes and SND.NXT from the header rules, using current field inputs.
    task automatic model(input tx_ctrl_t c);
        logic [31:0] seq, an;
        logic [7:0]  fl;
        exp_q = {};
        if (c == TX_CTRL_NOP)
            return;
        seq = (c == TX_CTRL_SEND_SYN) ? iss : m_snd;
        an  = (c == TX_CTRL_SEND_SYN) ? 32'h0 : rcv;
        fl  = (c == TX_CTRL_SEND_SYN) ? 8'h02 : (c == TX_CTRL_SEND_ACK) ? 8'h10 : 8'h11;
        push({16'h0, src}, 2);
        push({16'h0, dst}, 2);
        push(seq, 4);
        push(an, 4);
        push(32'h50, 1);
        push({24'h0, fl}, 1);
        push({16'h0, win}, 2);
        push(32'h0, 2);
        push(32'h0, 2);
        if (c == TX_CTRL_SEND_SYN)
            m_snd = iss + 32'd1;
        else if (c == TX_CTRL_SEND_FIN)
            m_snd = m_snd + 32'd1;
    endtask

    // mode: 0 tready high, 1 pattern 1,0,0,1, 2 random. pre: command already driven and acked.
    task automatic frame(input tx_ctrl_t c, input bit pre, input int mode, input bit hold,
                         input tx_ctrl_t nxt, input int drop_at);
        int         idx, cyc;
        logic       prev_rdy;
        logic [7:0] prev_d;
        logic [3:0] pat;
        pat = 4'b1001;
        if (!pre) begin
            @(negedge clk);
            bus.i_tx_ctrl = c;
            bus.i_tx_ctrl_valid = 1'b1;
            #1;
        end
        chk("accept_ack", bus.o_tx_ctrl_ack, 1);
        model(c);
        @(posedge clk);
        #1;
        if (hold)
            bus.i_tx_ctrl = nxt;
        else
            bus.i_tx_ctrl_valid = 1'b0;
        hs = 0;
        nl = 0;
        if (c == TX_CTRL_NOP) begin
            @(negedge clk);
            #1;
            chk("nop_idle", {busy, bus.o_m_axis_tvalid}, 2'b00);
            chk("nop_snd", snd_nxt, m_snd);
            return;
        end
        idx = 0;
        cyc = 0;
        prev_rdy = 1'b1;
        prev_d = 8'h00;
        while (idx < 20 && cyc < 200) begin
            @(negedge clk);
            bus.i_m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            if (idx == drop_at)
                enable = 1'b0;
            #1;
            chk("tvalid", bus.o_m_axis_tvalid, 1);
            chk($sformatf("tdata[%0d]", idx), bus.o_m_axis_tdata, exp_q[idx]);
            chk($sformatf("tlast[%0d]", idx), bus.o_m_axis_tlast, idx == 19);
            chk("busy_noack", {busy, bus.o_tx_ctrl_ack}, 2'b10);
            if (!prev_rdy)
                chk("stall_hold", bus.o_m_axis_tdata, prev_d);
            if (idx == 13)
                cap_flags = bus.o_m_axis_tdata;
            prev_rdy = bus.i_m_axis_tready;
            prev_d = bus.o_m_axis_tdata;
            if (bus.i_m_axis_tready) begin
                hs++;
                if (bus.o_m_axis_tlast)
                    nl++;
                idx++;
            end
            cyc++;
        end
        chk("frame_timeout", cyc < 200, 1);
        @(negedge clk);
        bus.i_m_axis_tready = 1'b0;
        #1;
        chk("done_idle", {busy, bus.o_m_axis_tvalid, bus.o_m_axis_tlast}, 3'b000);
        chk("done_snd", snd_nxt, m_snd);
        chk("done_ack", bus.o_tx_ctrl_ack, hold && enable);
    endtask

    initial begin
        tbl[0] = '{TX_CTRL_SEND_SYN, 16'h1234, 16'h0050, 32'h1000_0000, 32'h0,         16'h4000, 32'h1000_0001, 8'h02};
        tbl[1] = '{TX_CTRL_SEND_ACK, 16'h1234, 16'h0050, 32'h0000_DEAD, 32'hAABB_CCDD, 16'h4000, 32'h1000_0001, 8'h10};
        tbl[2] = '{TX_CTRL_SEND_FIN, 16'h8001, 16'h01BB, 32'h0,         32'h1122_3344, 16'hFFFF, 32'h1000_0002, 8'h11};
        tbl[3] = '{TX_CTRL_SEND_SYN, 16'h0001, 16'hFFFF, 32'hFFFF_FFFE, 32'h0,         16'h0000, 32'hFFFF_FFFF, 8'h02};
        tbl[4] = '{TX_CTRL_SEND_FIN, 16'h0001, 16'hFFFF, 32'h0,         32'h5555_AAAA, 16'h0100, 32'h0000_0000, 8'h11};
        tbl[5] = '{TX_CTRL_NOP,      16'h0001, 16'hFFFF, 32'h7777_7777, 32'h0,         16'h0100, 32'h0000_0000, 8'h00};

        rst_n = 1'b0;
        enable = 1'b1;
        bus.i_tx_ctrl = TX_CTRL_SEND_SYN;
        bus.i_tx_ctrl_valid = 1'b1;
        bus.i_m_axis_tready = 1'b0;
        {src, dst, win, iss, rcv} = '0;
        m_snd = 32'h0;
        #1;
        chk("rst_outputs", {bus.o_tx_ctrl_ack, bus.o_m_axis_tvalid, bus.o_m_axis_tlast, busy}, 4'b0000);
        chk("rst_tdata", bus.o_m_axis_tdata, 8'h00);
        chk("rst_snd", snd_nxt, 32'h0);
        repeat (2) @(negedge clk);
        bus.i_tx_ctrl_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            {src, dst, iss, rcv, win} = {tbl[i].src, tbl[i].dst, tbl[i].iss, tbl[i].rcv, tbl[i].win};
            frame(tbl[i].cmd, 1'b0, 0, 1'b0, TX_CTRL_NOP, -1);
            chk($sformatf("tbl%0d_snd", i), snd_nxt, tbl[i].exp_snd);
            if (tbl[i].cmd != TX_CTRL_NOP)
                chk($sformatf("tbl%0d_flags", i), cap_flags, tbl[i].exp_flags);
        end

        {src, dst, iss, win} = {16'h1234, 16'h0050, 32'h1000_0000, 16'h4000};
        frame(TX_CTRL_SEND_SYN, 1'b0, 1, 1'b0, TX_CTRL_NOP, -1);
        chk("stall_handshakes", hs, 20);
        chk("stall_tlast_count", nl, 1);

        rcv = 32'hCAFE_0001;
        frame(TX_CTRL_SEND_SYN, 1'b0, 0, 1'b1, TX_CTRL_SEND_ACK, -1);
        frame(TX_CTRL_SEND_ACK, 1'b1, 0, 1'b0, TX_CTRL_NOP, -1);

        frame(TX_CTRL_SEND_FIN, 1'b0, 0, 1'b1, TX_CTRL_SEND_ACK, 5);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("disabled_noack", {bus.o_tx_ctrl_ack, busy}, 2'b00);
        end
        enable = 1'b1;
        #1;
        frame(TX_CTRL_SEND_ACK, 1'b1, 0, 1'b0, TX_CTRL_NOP, -1);

        {src, dst, iss, rcv, win} = {16'hABCD, 16'h0016, 32'h2000_0000, 32'h0BAD_F00D, 16'h0800};
        @(negedge clk);
        bus.i_tx_ctrl = TX_CTRL_SEND_SYN;
        bus.i_tx_ctrl_valid = 1'b1;
        #1;
        chk("rst_seq_ack", bus.o_tx_ctrl_ack, 1);
        model(TX_CTRL_SEND_SYN);
        @(posedge clk);
        #1;
        bus.i_tx_ctrl = TX_CTRL_SEND_FIN;
        bus.i_m_axis_tready = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        chk("rst_seq_byte10", bus.o_m_axis_tdata, exp_q[10]);
        rst_n = 1'b0;
        m_snd = 32'h0;
        #1;
        chk("midrst_outputs", {bus.o_tx_ctrl_ack, bus.o_m_axis_tvalid, bus.o_m_axis_tlast, busy}, 4'b0000);
        chk("midrst_tdata", bus.o_m_axis_tdata, 8'h00);
        chk("midrst_snd", snd_nxt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_m_axis_tready = 1'b0;
        #1;
        frame(TX_CTRL_SEND_FIN, 1'b1, 0, 1'b0, TX_CTRL_NOP, -1);
        chk("post_rst_snd", snd_nxt, 32'h1);

        for (int i = 0; i < 30; i++) begin
            src = 16'($urandom);
            dst = 16'($urandom);
            iss = $urandom;
            rcv = $urandom;
            win = 16'($urandom);
            frame(tx_ctrl_t'($urandom_range(0, 3)), 1'b0, 2, 1'b0, TX_CTRL_NOP, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_tx_ctrl.md
TCP_TX_CTRL -- requirements
Module: tcp_tx_ctrl

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, rising edge; i_rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have: i_enable  in  1  block enable; low forces idle after any in-flight header.
REQ-003 SHALL have: i_tx_ctrl  in  tcp_pkg::tx_ctrl_t  command from state manager; i_tx_ctrl_valid  in  1  command present; o_tx_ctrl_ack  out  1  command accepted this cycle.
REQ-004 SHALL have: i_src_port  in  16  local port; i_dst_port  in  16  remote port; i_iss  in  32  initial send sequence; i_rcv_nxt  in  32  next expected remote sequence; i_window  in  16  advertised window.
REQ-005 SHALL have: o_m_axis_tdata  out  8  header byte; o_m_axis_tvalid  out  1; i_m_axis_tready  in  1; o_m_axis_tlast  out  1  final header byte; o_busy  out  1  header in flight; o_snd_nxt  out  32  current SND.NXT.

Function
REQ-006 SHALL use two states: IDLE and SEND.
REQ-007 o_tx_ctrl_ack SHALL be combinational: high iff state==IDLE and i_tx_ctrl_valid and i_enable; the command and all port/number inputs SHALL be captured on that edge.
REQ-008 TX_CTRL_NOP, when acked, SHALL emit nothing and stay IDLE.
REQ-009 SEND_SYN, SEND_ACK and SEND_FIN SHALL enter SEND on the accept edge; first byte valid the next cycle, so latency is 1 cycle.
REQ-010 Header SHALL be 20 bytes, big-endian, in this order: src port, dst port, seq, ack num, data-offset byte 0x50, flags, window, checksum 0x0000, urgent 0x0000.
REQ-011 SEND_SYN: seq=i_iss, ack num=0, flags=0x02, SND.NXT<=i_iss+1.
REQ-012 SEND_ACK: seq=SND.NXT, ack num=i_rcv_nxt, flags=0x10, SND.NXT unchanged.
REQ-013 SEND_FIN: seq=SND.NXT, ack num=i_rcv_nxt, flags=0x11, SND.NXT<=SND.NXT+1.
REQ-014 SND.NXT SHALL update on the accept edge; arithmetic is 32-bit modulo, so 0xFFFFFFFF+1=0x00000000.
REQ-015 A 5-bit byte counter SHALL advance only on tvalid&&tready; tdata SHALL hold stable while tready is low.
REQ-016 o_m_axis_tlast SHALL be high only on byte 19; the tvalid&&tready on byte 19 SHALL return the block to IDLE the next cycle.
REQ-017 A new command SHALL NOT be acked while in SEND; the upstream holds valid, and ack comes in the first IDLE cycle after completion.
REQ-018 i_enable low mid-header SHALL NOT truncate the frame; the header completes, the block idles, and no ack is issued while i_enable is low.
REQ-019 o_busy SHALL equal (state==SEND).
REQ-020 A checksum of 0x0000 SHALL be emitted; the downstream pseudo-header checksum stage fills it.

Reset
REQ-021 Asserting i_rst_n low SHALL immediately set: state=IDLE, counter=0, SND.NXT=0, o_m_axis_tvalid=0, o_m_axis_tlast=0, o_m_axis_tdata=0, o_busy=0, o_tx_ctrl_ack=0.
REQ-022 Reset mid-header SHALL abandon the frame with no tlast; the downstream discards partial frames.
REQ-023 Release SHALL be synchronised externally; the block needs no extra cycles after deassertion.

Structure
REQ-024 tcp_pkg SHALL hold tx_ctrl_t (NOP, SEND_SYN, SEND_ACK, SEND_FIN), the flag constants TCP_FLAG_SYN=0x02, TCP_FLAG_ACK=0x10 and TCP_FLAG_FIN=0x01, and TCP_HDR_BYTES=20.
REQ-025 The block SHALL be a single module with no sub-module; the header is a 160-bit shadow register selected by the byte counter.

Verification
REQ-026 SYN with i_iss=0x1000_0000, ports 0x1234/0x0050, window 0x4000, tready=1 -> ack in accept cycle; 20 bytes 12 34 00 50 10 00 00 00 00 00 00 00 50 02 40 00 00 00 00 00; tlast on byte 19; o_snd_nxt=0x1000_0001.
REQ-027 ACK after the SYN with i_rcv_nxt=0xAABB_CCDD -> seq bytes 10 00 00 01, ack bytes AA BB CC DD, flags 0x10; o_snd_nxt unchanged.
REQ-028 tready toggled 1,0,0,1 every other cycle through a SYN -> tdata stable during stalls, exactly 20 handshakes, one tlast.
REQ-029 FIN with SND.NXT=0xFFFF_FFFF -> seq FF FF FF FF, flags 0x11, o_snd_nxt=0x0000_0000.
REQ-030 Second command held valid during SEND -> no ack until the cycle after byte 19; i_enable dropped at byte 5 -> frame completes and no further ack.
REQ-031 i_rst_n pulsed low at byte 10 -> tvalid and all outputs 0 in the same cycle; SND.NXT=0.
